// File: rtl/sbox_1xn_drain.sv
// rtl/sbox_1xn_drain.sv - parametrised 1-to-N switching box with token buffer and drain-safe reconfiguration
//
// Optional feature macro: SBOX_SWITCH_COUNT_EN (adds cfg_switch_cnt output).
//
// Ports:
//   ap_clk          clock, all state updates on the rising edge
//   ap_rst          synchronous active-high reset
//   in1_data        input token from the producer
//   in1_full_n      box can accept a token this cycle
//   in1_write       producer write strobe (effective only with in1_full_n=1)
//   out_data        buffer head replicated to every branch, branch k at [k*SIZE +: SIZE]
//   out_full_n      per-branch consumer-not-full
//   out_write       per-branch write strobe, only the active branch can fire
//   sel             requested route from the network configurator
//   busy            buffer non-empty or a reconfiguration is in progress
//   cfg_switch_cnt  (SBOX_SWITCH_COUNT_EN) saturating count of effective route changes
module sbox_1xn_drain #(
    parameter int SIZE  = 32,
    parameter int N_OUT = 2,
    parameter int DEPTH = 2,
    localparam int SEL_W = $clog2(N_OUT)
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic [SIZE-1:0]       in1_data,
    output logic                  in1_full_n,
    input  logic                  in1_write,
    output logic [N_OUT*SIZE-1:0] out_data,
    input  logic [N_OUT-1:0]      out_full_n,
    output logic [N_OUT-1:0]      out_write,
    input  logic [SEL_W-1:0]      sel,
`ifdef SBOX_SWITCH_COUNT_EN
    output logic [15:0]           cfg_switch_cnt,
`endif
    output logic                  busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        SWITCH = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [SEL_W-1:0] active_sel;

    logic [SIZE-1:0]  mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;
    logic [SIZE-1:0]  head;

    assign head = mem[rd_ptr];

    // Input is only open while running on the requested route; a pending
    // select change closes it in the very cycle it is seen.
    assign in1_full_n = (state == RUN) && (sel == active_sel) && (count < CW'(DEPTH));
    assign push       = in1_write && in1_full_n;

    // A parked route (active_sel >= N_OUT) matches no branch, so nothing pops.
    always_comb begin
        out_write = '0;
        for (int k = 0; k < N_OUT; k++) begin
            out_write[k] = (SEL_W'(k) == active_sel) && (count != '0) && out_full_n[k];
        end
    end

    assign pop      = |out_write;
    assign out_data = {N_OUT{head}};
    assign busy     = (count != '0) || (state != RUN);

    always_ff @(posedge ap_clk) begin
        if (push) begin
            mem[wr_ptr] <= in1_data;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // active_sel only moves on reset and in SWITCH, which is reached only
    // after every token accepted on the old route has left the buffer.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state      <= RUN;
            active_sel <= sel;
        end else begin
            state <= state_nxt;
            if (state == SWITCH) begin
                active_sel <= sel;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (sel != active_sel) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (count == '0) begin
                    state_nxt = SWITCH;
                end
            end
            SWITCH: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

`ifdef SBOX_SWITCH_COUNT_EN
    logic [15:0] switch_cnt;

    // Only switches that actually change the route are counted, so a select
    // that reverts during DRAIN leaves the counter untouched.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            switch_cnt <= '0;
        end else if ((state == SWITCH) && (sel != active_sel) && (switch_cnt != 16'hFFFF)) begin
            switch_cnt <= switch_cnt + 16'd1;
        end
    end

    assign cfg_switch_cnt = switch_cnt;
`endif

endmodule

// File: tb/tb_sbox_1xn_drain.sv
// tb/tb_sbox_1xn_drain.sv - self-checking bench for sbox_1xn_drain (N_OUT=4, DEPTH=2)
module tb_sbox_1xn_drain;

    localparam int SIZE  = 32;
    localparam int N_OUT = 4;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [1:0]  br;
        logic [31:0] d;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [SIZE-1:0]       in1_data;
    logic                  in1_full_n;
    logic                  in1_write;
    logic [N_OUT*SIZE-1:0] out_data;
    logic [N_OUT-1:0]      out_full_n;
    logic [N_OUT-1:0]      out_write;
    logic [1:0]            sel;
    logic                  busy;
`ifdef SBOX_SWITCH_COUNT_EN
    logic [15:0]           cfg_switch_cnt;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t mon_e;
    int   stall;
    int   n_push;
    int   cyc;
    int   sels[5] = '{1, 3, 2, 0, 1};
    logic [31:0] t1[3] = '{32'h11, 32'h22, 32'h33};

    always #5 clk = ~clk;

    sbox_1xn_drain #(
        .SIZE  (SIZE),
        .N_OUT (N_OUT),
        .DEPTH (DEPTH)
    ) dut (
        .ap_clk         (clk),
        .ap_rst         (rst),
        .in1_data       (in1_data),
        .in1_full_n     (in1_full_n),
        .in1_write      (in1_write),
        .out_data       (out_data),
        .out_full_n     (out_full_n),
        .out_write      (out_write),
        .sel            (sel),
`ifdef SBOX_SWITCH_COUNT_EN
        .cfg_switch_cnt (cfg_switch_cnt),
`endif
        .busy           (busy)
    );

    function automatic exp_t mk(input logic [1:0] b, input logic [31:0] d);
        exp_t e;
        e.br = b;
        e.d  = d;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle_push(input logic [31:0] d, input logic [1:0] br, input logic acc, input string tag);
        in1_write = 1'b1;
        in1_data  = d;
        @(negedge clk);
        chk(tag, 64'(in1_full_n), 64'(acc));
        if (in1_full_n) q.push_back(mk(br, d));
        @(posedge clk); #1;
        in1_write = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!in1_full_n && n < 40) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(in1_full_n), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while ((q.size() != 0 || busy) && n < 80) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        chk(tag, {62'd0, q.size() == 0, busy}, 64'b10);
        @(posedge clk); #1;
    endtask

    // Scoreboard consumer: every strobe must be one-hot and match the oldest
    // expected token in both branch and data.
    always @(negedge clk) begin
        if (!rst && out_write != '0) begin
            chk("out_onehot", 64'($countones(out_write)), 64'd1);
            if (q.size() == 0) begin
                chk("out_unexpected", 64'(out_write), 64'd0);
            end else begin
                mon_e = q.pop_front();
                chk("out_branch", 64'(out_write), 64'(4'b0001 << mon_e.br));
                chk("out_data", 64'(out_data[mon_e.br*SIZE +: SIZE]), 64'(mon_e.d));
            end
        end
    end

    initial begin
        // Reset on route 1 and stream three tokens back to back.
        rst = 1'b1; sel = 2'd1; in1_write = 1'b0; in1_data = '0; out_full_n = '1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_write", 64'(out_write), 64'd0);
        chk("rst_full_n", 64'(in1_full_n), 64'd1);
`ifdef SBOX_SWITCH_COUNT_EN
        chk("rst_cnt", 64'(cfg_switch_cnt), 64'd0);
`endif
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            in1_write = 1'b1;
            in1_data  = t1[i];
            @(negedge clk);
            chk("t1_accept", 64'(in1_full_n), 64'd1);
            if (in1_full_n) q.push_back(mk(2'd1, t1[i]));
            if (i > 0) begin
                chk("t1_lat_write", 64'(out_write), 64'b0010);
                chk("t1_lat_data", 64'(out_data[63:32]), 64'(t1[i-1]));
            end
            @(posedge clk); #1;
        end
        in1_write = 1'b0;
        @(negedge clk);
        chk("t1_last_write", 64'(out_write), 64'b0010);
        chk("t1_last_data", 64'(out_data[63:32]), 64'h33);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_busy_drop", 64'(busy), 64'd0);
        chk("t1_idle_write", 64'(out_write), 64'd0);
        @(posedge clk); #1;

        // Route 0 with its consumer full: buffer holds DEPTH tokens, third refused.
        rst = 1'b1; sel = 2'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        out_full_n = 4'b1110;
        cycle_push(32'hA1, 2'd0, 1'b1, "t2_push1");
        cycle_push(32'hA2, 2'd0, 1'b1, "t2_push2");
        cycle_push(32'hA3, 2'd0, 1'b0, "t2_push3_refused");
        @(negedge clk);
        chk("t2_hold_write", 64'(out_write), 64'd0);
        chk("t2_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        out_full_n = '1;
        wait_idle("t2_drained");

        // Two tokens parked on branch 0, then request branch 2.
        out_full_n = 4'b1110;
        cycle_push(32'hB1, 2'd0, 1'b1, "t3_push1");
        cycle_push(32'hB2, 2'd0, 1'b1, "t3_push2");
        sel = 2'd2;
        in1_write = 1'b1;
        in1_data  = 32'hB3;
        stall = 0;
        @(negedge clk);
        while (!in1_full_n && stall < 40) begin
            stall++;
            @(posedge clk); #1;
            out_full_n = '1;
            @(negedge clk);
        end
        chk("t3_switch_stall", 64'(stall), 64'd5);
        if (in1_full_n) q.push_back(mk(2'd2, 32'hB3));
        @(posedge clk); #1;
        in1_write = 1'b0;
        wait_idle("t3_drained");

        // Reset with two tokens buffered on a blocked branch.
        out_full_n = 4'b1011;
        cycle_push(32'hC1, 2'd2, 1'b1, "t5_push1");
        cycle_push(32'hC2, 2'd2, 1'b1, "t5_push2");
        rst = 1'b1; sel = 2'd0; out_full_n = '1;
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_out_write", 64'(out_write), 64'd0);
        chk("t5_full_n", 64'(in1_full_n), 64'd1);
`ifdef SBOX_SWITCH_COUNT_EN
        chk("t5_cnt", 64'(cfg_switch_cnt), 64'd0);
`endif
        @(posedge clk); #1;

        // Select goes 0 -> 1 and back to 0 while draining: route must stay 0.
        out_full_n = 4'b1110;
        cycle_push(32'hD1, 2'd0, 1'b1, "t4_push1");
        cycle_push(32'hD2, 2'd0, 1'b1, "t4_push2");
        sel = 2'd1;
        @(negedge clk);
        chk("t4_block", 64'(in1_full_n), 64'd0);
        @(posedge clk); #1;
        sel = 2'd0;
        repeat (2) @(posedge clk);
        #1 out_full_n = '1;
        wait_ready("t4_ready");
        cycle_push(32'hD3, 2'd0, 1'b1, "t4_push3");
        wait_idle("t4_drained");
`ifdef SBOX_SWITCH_COUNT_EN
        chk("t4_cnt", 64'(cfg_switch_cnt), 64'd0);
`endif

        // Five back-to-back route changes, four tokens each, random backpressure.
        for (int s = 0; s < 5; s++) begin
            sel    = 2'(sels[s]);
            n_push = 0;
            cyc    = 0;
            while (n_push < 4 && cyc < 80) begin
                in1_write  = 1'b1;
                in1_data   = 32'hE000_0000 | 32'(s << 8) | 32'(n_push);
                out_full_n = 4'($urandom_range(0, 15));
                @(negedge clk);
                if (in1_full_n) begin
                    q.push_back(mk(2'(sels[s]), in1_data));
                    n_push++;
                end
                @(posedge clk); #1;
                cyc++;
            end
            in1_write = 1'b0;
            chk("t6_pushes", 64'(n_push), 64'd4);
        end
        out_full_n = '1;
        wait_idle("t6_drained");
`ifdef SBOX_SWITCH_COUNT_EN
        chk("t6_cnt", 64'(cfg_switch_cnt), 64'd5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
